router_1xn: RTL and testbench

Parametrised successor to the three-port byte router: one input stream, `N_PORTS` output FIFOs, configurable data width and FIFO depth. It decodes a header and reserves FIFO space for the whole packet before accepting any payload, so a packet never stalls mid-stream on a full FIFO. It drops illegal packets (bad address, zero or oversize length) and flushes any output FIFO whose reader stops draining it. It sits between the packet source and `N_PORTS` independent readers.

---
 rtl/router_1xn.sv | 226 ++++++++++++++++++++++
 tb/tb_router_1xn.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_1xn.sv
// router_1xn: one packet input stream routed to N_PORTS show-ahead FIFOs.
// Space for the whole packet (header + payload + parity) is reserved before
// the header is committed, so accepted payload never meets a full FIFO.
// Illegal headers are dropped with their bytes; stale FIFOs are flushed.
//
// state  | meaning
// -------+---------------------------------------------------------------
// DECODE | idle, next accepted byte is latched as a header
// CHECK  | one cycle: legality check and first free-space evaluation
// WAIT   | header legal but FIFO[dest] lacks len+2 free entries; retry
// LOAD   | header written, forwarding len payload bytes into FIFO[dest]
// PARITY | forwarding the parity byte and comparing it to running parity
// DROP   | discarding len+1 bytes of an illegal packet
module router_1xn #(
  parameter int N_PORTS    = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pkt_valid,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      busy,
  output logic                      err,
  input  logic [N_PORTS-1:0]        read_enb,
  output logic [N_PORTS-1:0]        vld_out,
  output logic [N_PORTS*DATA_W-1:0] data_out
);

  localparam int ADDR_W = (N_PORTS <= 2) ? 1 : $clog2(N_PORTS);
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int CNT_W  = LEN_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  // Wide enough for len+2 and FIFO_DEPTH without overflow
  localparam int CMP_W  = ((LEN_W > OCC_W) ? LEN_W : OCC_W) + 2;

  typedef enum logic [2:0] {
    S_DECODE,
    S_CHECK,
    S_WAIT,
    S_LOAD,
    S_PARITY,
    S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]   par_q, par_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   dest;
  logic [LEN_W-1:0]    len;
  logic [OCC_W-1:0]    occ_all [N_PORTS];
  logic [OCC_W-1:0]    occ_dest;
  logic [CMP_W-1:0]    need_w, free_w;
  logic                fits, pkt_bad;
  logic                wr_hdr, wr_byte, hold_st;
  logic [DATA_W-1:0]   wr_data;

  assign dest = hdr_q[ADDR_W-1:0];
  assign len  = hdr_q[DATA_W-1:ADDR_W];

  // Select the occupancy of the addressed FIFO (zero for an out-of-range dest)
  always_comb begin
    occ_dest = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (dest == ADDR_W'(k)) occ_dest = occ_all[k];
    end
  end

  // Legality and reservation checks on the latched header
  always_comb begin
    need_w  = CMP_W'(len) + CMP_W'(2);
    free_w  = CMP_W'(FIFO_DEPTH) - CMP_W'(occ_dest);
    fits    = (free_w >= need_w);
    pkt_bad = (int'(dest) >= N_PORTS) || (len == '0) || (need_w > CMP_W'(FIFO_DEPTH));
  end

  // FSM state and packet context registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_DECODE;
      hdr_q   <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // FSM next-state, handshake and FIFO write strobes
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    busy    = 1'b0;
    wr_hdr  = 1'b0;
    wr_byte = 1'b0;
    case (state_q)
      S_DECODE: begin
        if (pkt_valid) begin
          hdr_d   = data_in;
          par_d   = data_in;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (pkt_bad) begin
          err_d   = 1'b1;
          cnt_d   = CNT_W'(len) + CNT_W'(1);
          state_d = S_DROP;
        end else if (fits) begin
          wr_hdr  = 1'b1;
          cnt_d   = CNT_W'(len);
          state_d = S_LOAD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (fits) begin
          wr_hdr  = 1'b1;
          cnt_d   = CNT_W'(len);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pkt_valid) begin
          wr_byte = 1'b1;
          par_d   = par_q ^ data_in;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (pkt_valid) begin
          wr_byte = 1'b1;
          err_d   = (data_in != par_q);
          state_d = S_DECODE;
        end
      end
      S_DROP: begin
        if (pkt_valid) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DECODE;
        end
      end
      default: state_d = S_DECODE;
    endcase
  end

  assign err     = err_q;
  assign wr_data = wr_hdr ? hdr_q : data_in;
  // The port being filled must not be flushed underneath the packet
  assign hold_st = (state_q == S_CHECK) || (state_q == S_LOAD) || (state_q == S_PARITY);

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [TMR_W-1:0]  tmr;
    logic              vld, wr, rd, hold, flush;

    assign vld   = (occ != '0);
    assign wr    = (wr_hdr || wr_byte) && (dest == ADDR_W'(i));
    assign rd    = read_enb[i] && vld;
    assign hold  = hold_st && (dest == ADDR_W'(i));
    assign flush = (tmr == TMR_W'(TIMEOUT)) && !hold;

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
      if (wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; a flush keeps only a same-cycle write
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
        if (flush) begin
          rd_ptr <= wr_ptr;
          occ    <= wr ? OCC_W'(1) : '0;
        end else begin
          if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
          case ({wr, rd})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: ;
          endcase
        end
      end
    end

    // Stale-data timer: counts unread non-empty cycles up to TIMEOUT
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tmr <= '0;
      end else if (hold || !vld || read_enb[i] || flush) begin
        tmr <= '0;
      end else if (tmr != TMR_W'(TIMEOUT)) begin
        tmr <= tmr + TMR_W'(1);
      end
    end

    assign occ_all[i]                     = occ;
    assign vld_out[i]                     = vld;
    assign data_out[i*DATA_W +: DATA_W]   = vld ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn with default parameters.
module tb_router_1xn;

  localparam int N_PORTS    = 3;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 30;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      pkt_valid;
  logic [DATA_W-1:0]         data_in;
  logic                      busy;
  logic                      err;
  logic [N_PORTS-1:0]        read_enb;
  logic [N_PORTS-1:0]        vld_out;
  logic [N_PORTS*DATA_W-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  router_1xn #(
    .N_PORTS   (N_PORTS),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pkt_valid(pkt_valid),
    .data_in  (data_in),
    .busy     (busy),
    .err      (err),
    .read_enb (read_enb),
    .vld_out  (vld_out),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a byte and hold it until the router accepts it
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    pkt_valid = 1'b1;
    data_in   = b;
    while (busy && guard < 200) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    pkt_valid = 1'b0;
  endtask

  task automatic pop(input int p, input logic [7:0] exp);
    chk($sformatf("pop_vld_p%0d", p), 32'(vld_out[p]), 32'd1);
    chk($sformatf("pop_data_p%0d", p), 32'(data_out[p*DATA_W +: DATA_W]), 32'(exp));
    read_enb[p] = 1'b1;
    @(posedge clock);
    #1;
    read_enb = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset     = 1'b1;
    pkt_valid = 1'b0;
    data_in   = '0;
    read_enb  = '0;
    step(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_vld", 32'(vld_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    reset = 1'b0;
    step(1);

    // Good packet: dest 1, len 3
    send_byte(8'h0D);
    chk("t1_check_busy", 32'(busy), 32'd1);
    chk("t1_vld_in_check", 32'(vld_out), 32'd0);
    step(1);
    chk("t1_vld_rise", 32'(vld_out), 32'h2);
    chk("t1_load_busy", 32'(busy), 32'd0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hDD);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_other_ports", 32'(vld_out), 32'h2);
    pop(1, 8'h0D); pop(1, 8'hA1); pop(1, 8'hB2); pop(1, 8'hC3); pop(1, 8'hDD);
    chk("t1_empty", 32'(vld_out), 32'd0);

    // Bad parity: still stored, one-cycle err
    send_byte(8'h0D);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hDC);
    chk("t2_err_pulse", 32'(err), 32'd1);
    step(1);
    chk("t2_err_clear", 32'(err), 32'd0);
    pop(1, 8'h0D); pop(1, 8'hA1); pop(1, 8'hB2); pop(1, 8'hC3); pop(1, 8'hDC);

    // Bad destination: dest 3, len 2 -> 3 bytes dropped
    send_byte(8'h0B);
    chk("t3_err_in_check", 32'(err), 32'd0);
    step(1);
    chk("t3_err_pulse", 32'(err), 32'd1);
    chk("t3_drop_busy", 32'(busy), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("t3_err_clear", 32'(err), 32'd0);
    chk("t3_no_vld", 32'(vld_out), 32'd0);
    send_byte(8'h04);
    send_byte(8'h55);
    send_byte(8'h51);
    chk("t3_next_routes", 32'(vld_out), 32'h1);
    chk("t3_next_err", 32'(err), 32'd0);
    pop(0, 8'h04); pop(0, 8'h55); pop(0, 8'h51);

    // Oversize: dest 0, len 15 -> 16 bytes dropped
    send_byte(8'h3C);
    step(1);
    chk("t4_err_pulse", 32'(err), 32'd1);
    for (int i = 0; i < 16; i++) send_byte(8'hE0 + 8'(i));
    chk("t4_no_vld", 32'(vld_out), 32'd0);
    send_byte(8'h06);
    send_byte(8'h77);
    send_byte(8'h71);
    chk("t4_next_routes", 32'(vld_out), 32'h4);
    pop(2, 8'h06); pop(2, 8'h77); pop(2, 8'h71);

    // Zero length: header plus one byte dropped
    send_byte(8'h01);
    step(1);
    chk("t5_err_pulse", 32'(err), 32'd1);
    send_byte(8'hFF);
    send_byte(8'h04);
    send_byte(8'h55);
    send_byte(8'h51);
    chk("t5_next_err", 32'(err), 32'd0);
    pop(0, 8'h04); pop(0, 8'h55); pop(0, 8'h51);

    // Reservation wait: 10 entries in port 0, then a len-6 packet
    send_byte(8'h20);
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    send_byte(8'h20);
    chk("t6_first_err", 32'(err), 32'd0);
    send_byte(8'h18);
    step(2);
    chk("t6_wait_busy", 32'(busy), 32'd1);
    step(1);
    chk("t6_wait_busy2", 32'(busy), 32'd1);
    pop(0, 8'h20);
    pop(0, 8'h10);
    chk("t6_busy_after_reads", 32'(busy), 32'd1);
    step(1);
    chk("t6_released", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    send_byte(8'h19);
    chk("t6_second_err", 32'(err), 32'd0);
    for (int i = 1; i < 8; i++) pop(0, 8'h10 + 8'(i));
    pop(0, 8'h20);
    pop(0, 8'h18);
    for (int i = 0; i < 6; i++) pop(0, 8'hA0 + 8'(i));
    pop(0, 8'h19);
    chk("t6_drained", 32'(vld_out), 32'd0);

    // Flush: unread packet on port 2; timer starts once the packet is complete
    send_byte(8'h06);
    send_byte(8'h77);
    send_byte(8'h71);
    chk("t7_vld", 32'(vld_out), 32'h4);
    cnt = 0;
    while (vld_out[2] && cnt < 100) begin
      step(1);
      cnt++;
    end
    chk("t7_flush_delay", 32'(cnt), 32'd31);
    chk("t7_data_flushed", 32'(data_out), 32'd0);
    chk("t7_no_err", 32'(err), 32'd0);

    // Reset mid-packet while port 1 holds data
    send_byte(8'h0D); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hDD);
    send_byte(8'h0D);
    send_byte(8'hA1);
    chk("t8_pre_vld", 32'(vld_out), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("t8_rst_vld", 32'(vld_out), 32'd0);
    chk("t8_rst_data", 32'(data_out), 32'd0);
    chk("t8_rst_busy", 32'(busy), 32'd0);
    chk("t8_rst_err", 32'(err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1);
    send_byte(8'h04);
    send_byte(8'h55);
    send_byte(8'h51);
    chk("t8_after_rst_vld", 32'(vld_out), 32'h1);
    pop(0, 8'h04); pop(0, 8'h55); pop(0, 8'h51);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
